// File: rtl/exc_ctrl.sv
// Exception controller for the single-cycle LEGv8 core: synchronises the external IRQ,
// saves ELR/ESR on exceptions, redirects fetch to the vector, and returns on ERET.
module exc_ctrl #(
    parameter int              N        = 64,
    parameter logic [N-1:0]    VEC_ADDR = {{(N-8){1'b0}}, 8'hD8},
    parameter int              SYNC     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         irq_in,
    input  logic         Exc,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic [N-1:0] pc_cur,
    output logic         ExtIRQ,
    output logic         exc_redirect,
    output logic [N-1:0] exc_target,
    output logic [N-1:0] ELR,
    output logic [N-1:0] ESR,
    output logic         in_handler,
    output logic         halt,
    output logic [7:0]   exc_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HANDLER = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    localparam logic [3:0] CAUSE_IRQ  = 4'b0001;

    logic [1:0]      state_r;
    logic [SYNC-1:0] sync_r;
    logic            sync_last_r;
    logic            irq_pending_r;
    logic [N-1:0]    elr_r;
    logic [N-1:0]    esr_r;
    logic [7:0]      count_r;

    logic            irq_edge_s;
    logic            irq_clear_s;
    logic            redirect_s;
    logic [N-1:0]    target_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        if (val == 8'hFF) begin
            return val;
        end else begin
            return val + 8'd1;
        end
    endfunction

    assign irq_edge_s  = sync_r[SYNC-1] & ~sync_last_r;
    assign irq_clear_s = (state_r == ST_RUN) && Exc && (EStatus == CAUSE_IRQ);

    // Next-PC override: vector on a RUN exception, ELR on a clean ERET from the handler.
    always_comb begin
        redirect_s = 1'b0;
        target_s   = VEC_ADDR;
        case (state_r)
            ST_RUN: begin
                if (Exc) begin
                    redirect_s = 1'b1;
                    target_s   = VEC_ADDR;
                end else begin
                    redirect_s = 1'b0;
                    target_s   = VEC_ADDR;
                end
            end
            ST_HANDLER: begin
                if (Exc) begin
                    redirect_s = 1'b0;
                    target_s   = VEC_ADDR;
                end else if (ERet) begin
                    redirect_s = 1'b1;
                    target_s   = elr_r;
                end else begin
                    redirect_s = 1'b0;
                    target_s   = VEC_ADDR;
                end
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = VEC_ADDR;
            end
        endcase
    end

    // IRQ synchroniser and pending latch; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r        <= {SYNC{1'b0}};
            sync_last_r   <= 1'b0;
            irq_pending_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC-2:0], irq_in};
            sync_last_r <= sync_r[SYNC-1];
            if (irq_edge_s) begin
                irq_pending_r <= 1'b1;
            end else if (irq_clear_s) begin
                irq_pending_r <= 1'b0;
            end else begin
                irq_pending_r <= irq_pending_r;
            end
        end
    end

    // Exception state machine with ELR/ESR capture and saturating exception counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_RUN;
            elr_r   <= {N{1'b0}};
            esr_r   <= {N{1'b0}};
            count_r <= 8'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (Exc) begin
                        elr_r   <= pc_cur;
                        esr_r   <= {{(N-4){1'b0}}, EStatus};
                        count_r <= sat_inc(count_r);
                        state_r <= ST_HANDLER;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_HANDLER: begin
                    if (Exc) begin
                        esr_r   <= {{(N-4){1'b0}}, EStatus};
                        count_r <= sat_inc(count_r);
                        state_r <= ST_FAULT;
                    end else if (ERet) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_HANDLER;
                    end
                end
                ST_FAULT: begin
                    state_r <= ST_FAULT;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign ExtIRQ       = irq_pending_r & (state_r == ST_RUN);
    assign exc_redirect = redirect_s;
    assign exc_target   = target_s;
    assign ELR          = elr_r;
    assign ESR          = esr_r;
    assign in_handler   = (state_r == ST_HANDLER);
    assign halt         = (state_r == ST_FAULT);
    assign exc_count    = count_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: stimulus queues expected values tagged with a cycle number,
// and a negedge monitor compares every entry due in the current cycle.
module tb_exc_ctrl;

    localparam int N = 64;

    localparam int S_REDIR  = 0;
    localparam int S_TARGET = 1;
    localparam int S_ELR    = 2;
    localparam int S_ESR    = 3;
    localparam int S_INH    = 4;
    localparam int S_HALT   = 5;
    localparam int S_CNT    = 6;
    localparam int S_IRQ    = 7;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         irq_in;
    logic         Exc;
    logic [3:0]   EStatus;
    logic         ERet;
    logic [N-1:0] pc_cur;
    logic         ExtIRQ;
    logic         exc_redirect;
    logic [N-1:0] exc_target;
    logic [N-1:0] ELR;
    logic [N-1:0] ESR;
    logic         in_handler;
    logic         halt;
    logic [7:0]   exc_count;

    exp_t sbq[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   model_cnt;

    exc_ctrl dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .Exc(Exc), .EStatus(EStatus),
        .ERet(ERet), .pc_cur(pc_cur), .ExtIRQ(ExtIRQ), .exc_redirect(exc_redirect),
        .exc_target(exc_target), .ELR(ELR), .ESR(ESR), .in_handler(in_handler),
        .halt(halt), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] dut_val(input int sig);
        case (sig)
            S_REDIR:  return {63'd0, exc_redirect};
            S_TARGET: return exc_target;
            S_ELR:    return ELR;
            S_ESR:    return ESR;
            S_INH:    return {63'd0, in_handler};
            S_HALT:   return {63'd0, halt};
            S_CNT:    return {56'd0, exc_count};
            default:  return {63'd0, ExtIRQ};
        endcase
    endfunction

    // Monitor: compare every queued expectation due in this cycle.
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                total++;
                if (sbq[i].cyc < cyc) begin
                    bad++;
                    $display("FAIL %s: expectation for cycle %0d never sampled", sbq[i].name, sbq[i].cyc);
                end else if (dut_val(sbq[i].sig) !== sbq[i].val) begin
                    bad++;
                    $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h",
                             sbq[i].name, cyc, dut_val(sbq[i].sig), sbq[i].val);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic chk(input int sig, input logic [63:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic chkn(input int sig, input logic [63:0] val, input string name);
        exp_t e;
        e.cyc = cyc + 1; e.sig = sig; e.val = val; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic exc, input logic [3:0] es, input logic eret, input logic [63:0] pc);
        Exc = exc; EStatus = es; ERet = eret; pc_cur = pc;
    endtask

    initial begin
        reset = 1'b0; irq_in = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 64'd0);
        tick(); tick();
        // reset state
        chk(S_ELR, 64'd0, "rst_elr"); chk(S_ESR, 64'd0, "rst_esr"); chk(S_CNT, 64'd0, "rst_cnt");
        chk(S_INH, 64'd0, "rst_inh"); chk(S_HALT, 64'd0, "rst_halt"); chk(S_IRQ, 64'd0, "rst_irq");
        chk(S_REDIR, 64'd0, "rst_redir");
        reset = 1'b1;
        tick();

        // illegal opcode in RUN
        drive(1'b1, 4'b0010, 1'b0, 64'h40);
        chk(S_REDIR, 64'd1, "t1_redir"); chk(S_TARGET, 64'hD8, "t1_target");
        chkn(S_ELR, 64'h40, "t1_elr"); chkn(S_ESR, 64'h2, "t1_esr");
        chkn(S_INH, 64'd1, "t1_inh"); chkn(S_CNT, 64'd1, "t1_cnt");
        tick();

        // ERET back to 0x40
        drive(1'b0, 4'd0, 1'b1, 64'h44);
        chk(S_REDIR, 64'd1, "t2_redir"); chk(S_TARGET, 64'h40, "t2_target");
        chkn(S_INH, 64'd0, "t2_inh"); chkn(S_ELR, 64'h40, "t2_elr_hold");
        tick();
        drive(1'b0, 4'd0, 1'b0, 64'h48);
        chk(S_REDIR, 64'd0, "t2_idle_redir");
        tick();

        // IRQ edge in RUN -> ExtIRQ at t+3
        irq_in = 1'b1;
        chk(S_IRQ, 64'd0, "t3_irq_t0"); tick();
        chk(S_IRQ, 64'd0, "t3_irq_t1"); tick();
        chk(S_IRQ, 64'd0, "t3_irq_t2"); tick();
        chk(S_IRQ, 64'd1, "t3_irq_t3");
        drive(1'b1, 4'b0001, 1'b0, 64'h100);
        chk(S_REDIR, 64'd1, "t3_redir");
        chkn(S_ELR, 64'h100, "t3_elr"); chkn(S_ESR, 64'h1, "t3_esr");
        chkn(S_IRQ, 64'd0, "t3_irq_clr"); chkn(S_CNT, 64'd2, "t3_cnt");
        tick();
        drive(1'b0, 4'd0, 1'b0, 64'hD8);

        // IRQ edge while in HANDLER stays masked
        irq_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk(S_IRQ, 64'd0, "t4_irq_low"); tick();
        end
        irq_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk(S_IRQ, 64'd0, "t4_irq_masked"); tick();
        end
        drive(1'b0, 4'd0, 1'b1, 64'hDC);
        chk(S_REDIR, 64'd1, "t4_redir"); chk(S_TARGET, 64'h100, "t4_target");
        chkn(S_INH, 64'd0, "t4_inh"); chkn(S_IRQ, 64'd1, "t4_irq_after_ret");
        tick();
        drive(1'b1, 4'b0001, 1'b0, 64'h200);
        chkn(S_ELR, 64'h200, "t4_elr"); chkn(S_CNT, 64'd3, "t4_cnt"); chkn(S_IRQ, 64'd0, "t4_irq_clr");
        tick();

        // fault inside handler
        drive(1'b1, 4'b0010, 1'b0, 64'h300);
        chk(S_REDIR, 64'd0, "t5_redir");
        chkn(S_HALT, 64'd1, "t5_halt"); chkn(S_ELR, 64'h200, "t5_elr_hold");
        chkn(S_ESR, 64'h2, "t5_esr"); chkn(S_CNT, 64'd4, "t5_cnt"); chkn(S_INH, 64'd0, "t5_inh");
        tick();
        drive(1'b0, 4'd0, 1'b1, 64'h304);
        chk(S_REDIR, 64'd0, "t5_eret_redir"); chkn(S_HALT, 64'd1, "t5_halt_eret");
        tick();
        drive(1'b1, 4'b0010, 1'b0, 64'h308);
        chk(S_REDIR, 64'd0, "t5_exc_redir"); chkn(S_HALT, 64'd1, "t5_halt_exc"); chkn(S_CNT, 64'd4, "t5_cnt_hold");
        tick();
        drive(1'b0, 4'd0, 1'b0, 64'd0);
        irq_in = 1'b0;
        reset = 1'b0;
        chkn(S_HALT, 64'd0, "t5_rst_halt"); chkn(S_CNT, 64'd0, "t5_rst_cnt");
        chkn(S_INH, 64'd0, "t5_rst_inh"); chkn(S_ELR, 64'd0, "t5_rst_elr");
        tick();
        reset = 1'b1;
        tick();

        // Exc and ERet together in RUN: exception wins
        drive(1'b1, 4'b0010, 1'b1, 64'h40);
        chk(S_REDIR, 64'd1, "t6_redir"); chk(S_TARGET, 64'hD8, "t6_target");
        chkn(S_INH, 64'd1, "t6_inh"); chkn(S_CNT, 64'd1, "t6_cnt"); chkn(S_ELR, 64'h40, "t6_elr");
        tick();
        model_cnt = 1;
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 4'd0, 1'b1, 64'h0);
            chk(S_REDIR, 64'd1, "sat_ret_redir");
            tick();
            drive(1'b1, 4'b0010, 1'b0, 64'(i * 4));
            model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
            chkn(S_CNT, 64'(model_cnt), "sat_cnt");
            tick();
        end
        chk(S_CNT, 64'hFF, "sat_final");
        // Exc and ERet together in HANDLER: exception wins -> fault
        drive(1'b1, 4'b0010, 1'b1, 64'h500);
        chk(S_REDIR, 64'd0, "t6_h_redir");
        chkn(S_HALT, 64'd1, "t6_h_halt"); chkn(S_ELR, 64'(259 * 4), "t6_h_elr");
        tick();
        drive(1'b0, 4'd0, 1'b0, 64'd0);

        for (int i = 0; i < 10 && sbq.size() != 0; i++) tick();
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
